// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
//   Instruction-memory fetch handshake between the sequencer and imem.
//   req   : fetch request, held high while the sequencer is fetching
//   addr  : fetch address (the current PC)
//   ack   : imem has valid data this cycle
//   rdata : instruction word, valid when req && ack
// ---------------------------------------------------------------------------
interface instr_sequencer_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ack;
    logic [31:0]           rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle FETCH/DECODE/EXEC/WB controller for the reduced RV32 datapath
//   (addi, bne). Owns PC and IR, runs the imem handshake, drives datapath
//   control one phase at a time and halts on illegal instructions, misaligned
//   branch targets and fetch timeouts.
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : begin execution at PC=0 (honoured in IDLE/HALT only)
//   imem           : fetch handshake (master side)
//   i_ne           : ALU compare result rs1 != rs2
//   i_imm_ext      : sign-extended B-type offset
//   o_instr, o_pc  : instruction register and program counter
//   o_regwrite     : register-file write strobe (WB only)
//   o_aluctrl      : ALU op, always add
//   o_alusrc       : 1 = immediate operand, 0 = register
//   o_immsrc       : 0 = I-type, 1 = B-type immediate
//   o_busy         : executing (FETCH..WB)
//   o_illegal      : sticky bad opcode/funct3 or misaligned branch target
//   o_timeout      : sticky missing imem ack
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    instr_sequencer_if.master     imem,
    input  logic                  i_ne,
    input  logic [ADDR_WIDTH-1:0] i_imm_ext,
    output logic [31:0]           o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_regwrite,
    output logic [2:0]            o_aluctrl,
    output logic                  o_alusrc,
    output logic                  o_immsrc,
    output logic                  o_busy,
    output logic                  o_illegal,
    output logic                  o_timeout
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [31:0]           r_ir;
    logic [CW-1:0]         r_wait;
    logic                  r_illegal, r_timeout;

    logic                  w_is_addi, w_is_bne, w_wait_last, w_misalign;
    logic [ADDR_WIDTH-1:0] w_tgt_taken, w_pc_plus4;

    assign w_is_addi   = (r_ir[6:0] == 7'h13) && (r_ir[14:12] == 3'b000);
    assign w_is_bne    = (r_ir[6:0] == 7'h63) && (r_ir[14:12] == 3'b001);
    assign w_tgt_taken = r_pc + i_imm_ext;
    assign w_pc_plus4  = r_pc + ADDR_WIDTH'(4);
    // Only a taken branch can land misaligned; pc+4 is always aligned.
    assign w_misalign  = i_ne && (w_tgt_taken[1:0] != 2'b00);
    // r_wait counts ack-less FETCH cycles already spent; this is the last allowed one.
    assign w_wait_last = (r_wait == CW'(MAX_WAIT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        imem.req   = 1'b0;
        o_regwrite = 1'b0;
        o_alusrc   = 1'b1;
        o_immsrc   = 1'b0;
        o_busy     = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_FETCH;
            S_FETCH: begin
                o_busy   = 1'b1;
                imem.req = 1'b1;
                if (imem.ack)        w_next = S_DECODE;
                else if (w_wait_last) w_next = S_HALT;
            end
            S_DECODE: begin
                o_busy = 1'b1;
                w_next = (w_is_addi || w_is_bne) ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                o_busy = 1'b1;
                if (w_is_bne) begin
                    o_alusrc = 1'b0;
                    o_immsrc = 1'b1;
                    w_next   = w_misalign ? S_HALT : S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                o_busy     = 1'b1;
                o_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT: if (i_start) w_next = S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            // Cleared whenever outside FETCH, so every FETCH entry starts at 0.
            if (r_state != S_FETCH)  r_wait <= '0;
            else if (!imem.ack)      r_wait <= r_wait + CW'(1);

            case (r_state)
                S_IDLE, S_HALT: if (i_start) begin
                    r_pc      <= '0;
                    r_illegal <= 1'b0;
                    r_timeout <= 1'b0;
                end
                S_FETCH: begin
                    if (imem.ack)         r_ir      <= imem.rdata;
                    else if (w_wait_last) r_timeout <= 1'b1;
                end
                S_DECODE: if (!(w_is_addi || w_is_bne)) r_illegal <= 1'b1;
                S_EXEC: if (w_is_bne) begin
                    if (w_misalign) r_illegal <= 1'b1;
                    else            r_pc      <= i_ne ? w_tgt_taken : w_pc_plus4;
                end
                S_WB: r_pc <= w_pc_plus4;
                default: ;
            endcase
        end
    end

    assign imem.addr = r_pc;
    assign o_pc      = r_pc;
    assign o_instr   = r_ir;
    assign o_aluctrl = 3'b000;
    assign o_illegal = r_illegal;
    assign o_timeout = r_timeout;
endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
    logic        clk, rst_n, start, ne;
    logic [31:0] imm_ext, instr, pc;
    logic        regwrite, alusrc, immsrc, busy, illegal, timeout;
    logic [2:0]  aluctrl;

    instr_sequencer_if #(.ADDR_WIDTH(32)) imem ();

    instr_sequencer #(.ADDR_WIDTH(32), .MAX_WAIT(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .imem(imem),
        .i_ne(ne), .i_imm_ext(imm_ext), .o_instr(instr), .o_pc(pc),
        .o_regwrite(regwrite), .o_aluctrl(aluctrl), .o_alusrc(alusrc),
        .o_immsrc(immsrc), .o_busy(busy), .o_illegal(illegal), .o_timeout(timeout)
    );

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] BNE  = 32'h0020_9063;
    localparam logic [31:0] RADD = 32'h0000_0033;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed events: a fetch starting (imem_req rising) or execution halting (busy falling).
    typedef struct {
        bit          halt;
        logic [31:0] pc;
        bit          ill;
        bit          tmo;
        int          rw;
        int          cyc;
        bit          chk_cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic push(input bit h, input logic [31:0] p, input bit il, input bit tm,
                        input int r, input int c, input bit cc);
        ev_t e;
        e.halt = h; e.pc = p; e.ill = il; e.tmo = tm; e.rw = r; e.cyc = c; e.chk_cyc = cc;
        exp_q.push_back(e);
    endtask

    // Monitor / scoreboard
    bit prev_req, prev_busy;
    int m_cyc, m_rw, ev_idx = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0; prev_busy = 1'b0; m_cyc = 0; m_rw = 0;
        end else begin
            m_cyc++;
            if (regwrite) m_rw++;
            if ((imem.req && !prev_req) || (!busy && prev_busy)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ev%0d unexpected event halt=%0b pc=%h", ev_idx, !busy, pc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if ((!busy) !== e.halt || pc !== e.pc || imem.addr !== e.pc ||
                        illegal !== e.ill || timeout !== e.tmo || m_rw != e.rw ||
                        (e.chk_cyc && m_cyc != e.cyc)) begin
                        failures++;
                        $display("FAIL ev%0d act halt=%0b pc=%h addr=%h ill=%0b tmo=%0b rw=%0d cyc=%0d exp halt=%0b pc=%h ill=%0b tmo=%0b rw=%0d cyc=%0d(chk=%0b)",
                                 ev_idx, !busy, pc, imem.addr, illegal, timeout, m_rw, m_cyc,
                                 e.halt, e.pc, e.ill, e.tmo, e.rw, e.cyc, e.chk_cyc);
                    end
                end
                ev_idx++;
                m_cyc = 0;
                m_rw  = 0;
            end
            prev_req  = imem.req;
            prev_busy = busy;
        end
    end

    // Stimulus helpers (all return on a negedge)
    task automatic wait_req();
        for (int i = 0; i < 60; i++) begin
            if (imem.req) return;
            @(negedge clk);
        end
        chk("wait_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 60; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        chk("wait_halt_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // kind: 0 = illegal (no EXEC), 1 = addi, 2 = bne
    task automatic serve(input logic [31:0] w, input int waits, input int kind);
        wait_req();
        repeat (waits) @(negedge clk);
        imem.ack = 1'b1; imem.rdata = w;
        @(negedge clk);
        imem.ack = 1'b0; imem.rdata = 32'h0;
        chk("ir_latch", instr, w);
        if (kind != 0) begin
            @(negedge clk);
            chk("exec_alusrc", {31'd0, alusrc}, (kind == 1) ? 32'd1 : 32'd0);
            chk("exec_immsrc", {31'd0, immsrc}, (kind == 2) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic bne_op(input logic [31:0] off, input bit n);
        imm_ext = off; ne = n;
        serve(BNE, 0, 2);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ne = 1'b0; imm_ext = '0;
        imem.ack = 1'b0; imem.rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ir", instr, 32'd0);
        chk("rst_ctl", {24'd0, imem.req, regwrite, busy, illegal, timeout, aluctrl == 3'd0, alusrc, immsrc},
            32'b0000_0110);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: reset mid-FETCH
        push(0, 32'h0, 0, 0, 0, 0, 0);
        pulse_start();
        wait_req();
        #2 rst_n = 1'b0;
        #1 chk("rst_async_req", {31'd0, imem.req}, 32'd0);
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_no_req", {31'd0, imem.req}, 32'd0);
        end
        chk("idle_pc", pc, 32'd0);

        // 2: addi twice -> pc 8
        push(0, 32'h0, 0, 0, 0, 0, 0);
        pulse_start();
        push(0, 32'h4, 0, 0, 1, 4, 1); serve(ADDI, 0, 1);
        push(0, 32'h8, 0, 0, 1, 4, 1); serve(ADDI, 0, 1);

        // 3: bne -8 taken -> 0; back to 8; bne not taken -> 12
        push(0, 32'h0, 0, 0, 0, 3, 1); bne_op(32'hFFFF_FFF8, 1'b1);
        push(0, 32'h4, 0, 0, 1, 4, 1); serve(ADDI, 0, 1);
        push(0, 32'h8, 0, 0, 1, 4, 1); serve(ADDI, 0, 1);
        push(0, 32'hC, 0, 0, 0, 3, 1); bne_op(32'hFFFF_FFF8, 1'b0);

        // 4: back to 8, misaligned taken branch -> illegal halt at pc 8, restart
        push(0, 32'h8, 0, 0, 0, 3, 1); bne_op(32'hFFFF_FFFC, 1'b1);
        push(1, 32'h8, 1, 0, 0, 3, 1); bne_op(32'h0000_0006, 1'b1);
        wait_halt();
        push(0, 32'h0, 0, 0, 0, 0, 0);
        pulse_start();

        // 5: fetch timeout, ir unchanged; then ack on the 8th cycle
        push(1, 32'h0, 0, 1, 0, 8, 1);
        wait_halt();
        chk("timeout_ir_kept", instr, BNE);
        push(0, 32'h0, 0, 0, 0, 0, 0);
        pulse_start();
        push(0, 32'h4, 0, 0, 1, 11, 1); serve(ADDI, 7, 1);

        // 6: R-type add -> illegal; PC wrap through 0xFFFFFFFC
        push(1, 32'h4, 1, 0, 0, 2, 1); serve(RADD, 0, 0);
        wait_halt();
        push(0, 32'h0, 0, 0, 0, 0, 0);
        pulse_start();
        push(0, 32'hFFFF_FFFC, 0, 0, 0, 3, 1); bne_op(32'hFFFF_FFFC, 1'b1);
        push(0, 32'h0, 0, 0, 1, 4, 1); serve(ADDI, 0, 1);
        push(1, 32'h0, 1, 0, 0, 2, 1); serve(RADD, 0, 0);
        wait_halt();
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
